clksel_sched: RTL and testbench

//  Speed-switch sequencer for the dual-clock CPU clock mux (HS/LS glitch-free switcher).
//  - Decides when the CPU runs from the high-speed divider and when it runs from the delayed host clock.
//  - Drives the mux's hsclk_sel and cpuclk_div_sel.
//  - Waits for the mux's selected-clock feedback, handshaking with slow-clock requesters
//    (host bus access, I/O, forced-slow config).
//  - Applies an anti-thrash holdoff before returning to HS.
//  - Flags a sticky error if the mux never acknowledges.

---
 rtl/clksel_pkg.sv | 14 +
 rtl/clksel_sync.sv | 22 ++
 rtl/clksel_sched.sv | 153 +++++++++++++++
 tb/tb_clksel_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clksel_pkg.sv
// Shared encodings for the CPU clock speed-switch sequencer.
// State codes and HS divider settings used by the mux interface.
package clksel_pkg;

  localparam logic [1:0] CS_LS    = 2'd0;
  localparam logic [1:0] CS_TO_HS = 2'd1;
  localparam logic [1:0] CS_HS    = 2'd2;
  localparam logic [1:0] CS_TO_LS = 2'd3;

  localparam logic [1:0] DIV_1 = 2'b00;
  localparam logic [1:0] DIV_2 = 2'b01;
  localparam logic [1:0] DIV_4 = 2'b10;

endpackage

// File: rtl/clksel_sync.sv
// Multi-flop 1-bit synchroniser for asynchronous mux feedback.
// Clears on async active-high reset.
module clksel_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_LEN-1:0] sync_q;

  // shift the async input through the chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_LEN-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_LEN-1];

endmodule

// File: rtl/clksel_sched.sv
// Speed-switch sequencer driving the HS/LS glitch-free CPU clock mux.
// Handles holdoff, slow requesters, ack timeout and sticky error.
module clksel_sched
  import clksel_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SYNC_LEN = 2,
  parameter int HOLDOFF  = 16,
  parameter int TIMEOUT  = 255,
  parameter int TW       = 8
) (
  input  logic            hsclk_in,
  input  logic            rst,
  input  logic            fast_en,
  input  logic [1:0]      div_cfg,
  input  logic [NREQ-1:0] slow_req,
  input  logic            hsclk_selected,
  input  logic            lsclk_selected,
  output logic            hsclk_sel,
  output logic [1:0]      cpuclk_div_sel,
  output logic [NREQ-1:0] slow_gnt,
  output logic            mode_hs,
  output logic            busy,
  output logic            timeout_err
);

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF - 1);
  localparam logic [TW-1:0] TMO       = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMAX      = '1;

  logic            hs_ack, ls_ack;
  logic            hs_ok, ls_ok, want_ls;
  logic [1:0]      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic            err_q, err_d;
  logic            hsel_q, mode_q, busy_q;
  logic [1:0]      div_q;
  logic [NREQ-1:0] gnt_q;

  clksel_sync #(.SYNC_LEN(SYNC_LEN)) u_sync_hs (
    .clk_i (hsclk_in),
    .rst_i (rst),
    .d_i   (hsclk_selected),
    .q_o   (hs_ack)
  );

  clksel_sync #(.SYNC_LEN(SYNC_LEN)) u_sync_ls (
    .clk_i (hsclk_in),
    .rst_i (rst),
    .d_i   (lsclk_selected),
    .q_o   (ls_ack)
  );

  // both-high or both-low feedback means the mux is still switching
  assign hs_ok     = hs_ack & ~ls_ack;
  assign ls_ok     = ls_ack & ~hs_ack;
  assign want_ls   = (|slow_req) | ~fast_en | err_q;
  assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;

  // next-state, shared timer and sticky error
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      CS_LS: begin
        if (want_ls) begin
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          state_d = CS_TO_HS;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      CS_TO_HS: begin
        if (want_ls) begin
          state_d = CS_TO_LS;
          timer_d = '0;
        end else if (hs_ok) begin
          state_d = CS_HS;
          timer_d = '0;
        end else if (timer_q == TMO) begin
          err_d   = 1'b1;
          state_d = CS_TO_LS;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      CS_HS: begin
        if (want_ls) begin
          state_d = CS_TO_LS;
          timer_d = '0;
        end
      end
      CS_TO_LS: begin
        if (ls_ok) begin
          state_d = CS_LS;
          timer_d = '0;
        end else if (timer_q == TMO) begin
          err_d   = 1'b1;
          state_d = CS_LS;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = CS_LS;
        timer_d = '0;
      end
    endcase
  end

  // state, timer and error registers
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state_q <= CS_LS;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // registered mux controls and status decoded from the next state
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      hsel_q <= 1'b0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      gnt_q  <= '0;
      div_q  <= DIV_1;
    end else begin
      hsel_q <= (state_d == CS_TO_HS) || (state_d == CS_HS);
      mode_q <= (state_d == CS_HS);
      busy_q <= (state_d == CS_TO_HS) || (state_d == CS_TO_LS);
      gnt_q  <= ((state_d == CS_LS) && ls_ack) ? slow_req : '0;
      if (state_d == CS_LS) div_q <= div_cfg;
    end
  end

  assign hsclk_sel      = hsel_q;
  assign cpuclk_div_sel = div_q;
  assign slow_gnt       = gnt_q;
  assign mode_hs        = mode_q;
  assign busy           = busy_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_clksel_sched.sv
// Randomised scoreboard bench for clksel_sched.
// Reference model plus mux model predict every cycle's outputs.
module tb_clksel_sched;

  localparam int NREQ     = 4;
  localparam int SYNC_LEN = 2;
  localparam int HOLDOFF  = 16;
  localparam int TIMEOUT  = 255;
  localparam int TW       = 8;
  localparam int ACK_DLY  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fast_en = 1'b1;
  logic [1:0] div_cfg = 2'b00;
  logic [3:0] slow_req = 4'b0;
  logic       hsclk_selected = 1'b0;
  logic       lsclk_selected = 1'b1;
  logic       hsclk_sel, mode_hs, busy, timeout_err;
  logic [1:0] cpuclk_div_sel;
  logic [3:0] slow_gnt;

  always #5 clk = ~clk;

  clksel_sched #(
    .NREQ(NREQ), .SYNC_LEN(SYNC_LEN), .HOLDOFF(HOLDOFF),
    .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .hsclk_in       (clk),
    .rst            (rst),
    .fast_en        (fast_en),
    .div_cfg        (div_cfg),
    .slow_req       (slow_req),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .slow_gnt       (slow_gnt),
    .mode_hs        (mode_hs),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  typedef struct packed {
    logic       hsel;
    logic [1:0] div;
    logic [3:0] gnt;
    logic       mhs;
    logic       busy;
    logic       err;
  } obs_t;

  obs_t expq[$];
  int   checks = 0;
  int   failures = 0;

  typedef enum {M_LS, M_GO_HS, M_HS, M_GO_LS} mm_t;
  mm_t  m;
  int   idle_run, wait_cyc;
  bit   err;
  obs_t mo;
  bit   hs_hist[SYNC_LEN];
  bit   ls_hist[SYNC_LEN];

  bit   mux_sel = 1'b0;
  int   mux_age = 100;
  bit   mux_hs_ok = 1'b1;

  bit   rise_armed = 1'b0;
  int   edge_n = 0;
  bit   thrash_win = 1'b0;
  int   thrash_bad = 0;

  function automatic void model_reset();
    m = M_LS;
    idle_run = 0;
    wait_cyc = 0;
    err = 1'b0;
    mo = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      hs_hist[i] = 1'b0;
      ls_hist[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    bit hs_a, ls_a, want;
    hs_a = hs_hist[SYNC_LEN-1];
    ls_a = ls_hist[SYNC_LEN-1];
    for (int i = SYNC_LEN - 1; i > 0; i--) begin
      hs_hist[i] = hs_hist[i-1];
      ls_hist[i] = ls_hist[i-1];
    end
    hs_hist[0] = hsclk_selected;
    ls_hist[0] = lsclk_selected;
    want = (slow_req != 0) || !fast_en || err;
    case (m)
      M_LS:
        if (want) idle_run = 0;
        else if (idle_run == HOLDOFF - 1) begin
          m = M_GO_HS;
          wait_cyc = 0;
        end else idle_run++;
      M_GO_HS:
        if (want) begin
          m = M_GO_LS;
          wait_cyc = 0;
        end else if (hs_a && !ls_a) m = M_HS;
        else if (wait_cyc == TIMEOUT) begin
          err = 1'b1;
          m = M_GO_LS;
          wait_cyc = 0;
        end else wait_cyc++;
      M_HS:
        if (want) begin
          m = M_GO_LS;
          wait_cyc = 0;
        end
      M_GO_LS:
        if (ls_a && !hs_a) begin
          m = M_LS;
          idle_run = 0;
        end else if (wait_cyc == TIMEOUT) begin
          err = 1'b1;
          m = M_LS;
          idle_run = 0;
        end else wait_cyc++;
    endcase
    mo.hsel = (m == M_GO_HS) || (m == M_HS);
    mo.mhs  = (m == M_HS);
    mo.busy = (m == M_GO_HS) || (m == M_GO_LS);
    mo.err  = err;
    mo.gnt  = (m == M_LS && ls_a) ? slow_req : 4'b0;
    if (m == M_LS) mo.div = div_cfg;
  endfunction

  function automatic void mux_update();
    if (mo.hsel != mux_sel) begin
      mux_sel = mo.hsel;
      mux_age = 0;
    end else if (mux_age < 100) mux_age++;
    hsclk_selected = mux_sel && mux_hs_ok && (mux_age >= ACK_DLY);
    lsclk_selected = !mux_sel && (mux_age >= ACK_DLY);
  endfunction

  task automatic cyc(input logic [3:0] req, input logic fen,
                     input logic [1:0] dc, input logic r);
    @(negedge clk);
    mux_update();
    slow_req = req;
    fast_en = fen;
    div_cfg = dc;
    rst = r;
    if (rst) model_reset();
    else model_step();
    expq.push_back(mo);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    obs_t e, g;
    #1;
    if (rst) edge_n = 0;
    else edge_n++;
    g = '{hsclk_sel, cpuclk_div_sel, slow_gnt, mode_hs, busy, timeout_err};
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=%h t=%0t", g, $time);
    end else begin
      e = expq.pop_front();
      if (g !== e) begin
        failures++;
        $display("FAIL outputs got=%h exp=%h t=%0t", g, e, $time);
      end
    end
    if (rise_armed && hsclk_sel) begin
      rise_armed = 1'b0;
      checks++;
      if (edge_n != HOLDOFF) begin
        failures++;
        $display("FAIL hs_rise_cycle got=%0d exp=%0d", edge_n, HOLDOFF);
      end
    end
    if (thrash_win && hsclk_sel) thrash_bad++;
  end

  initial begin
    int n;
    logic [3:0] rq;
    model_reset();
    expq.push_back(mo);
    #1;
    chk("reset_outputs",
        {hsclk_sel, cpuclk_div_sel, slow_gnt, mode_hs, busy, timeout_err}, 0);
    repeat (2) cyc(4'b0, 1'b1, 2'b00, 1'b1);
    rise_armed = 1'b1;
    repeat (40) cyc(4'b0, 1'b1, 2'b00, 1'b0);
    chk("hs_reached", mode_hs, 1);

    repeat (30) cyc(4'b0100, 1'b1, 2'b00, 1'b0);
    chk("slow_gnt_req2", slow_gnt, 4'b0100);
    repeat (40) cyc(4'b0, 1'b1, 2'b00, 1'b0);
    chk("hs_after_req", mode_hs, 1);

    repeat (10) cyc(4'b0001, 1'b1, 2'b00, 1'b0);
    thrash_win = 1'b1;
    for (int k = 1; k < 8; k++)
      repeat (10) cyc((k % 2 == 0) ? 4'b0001 : 4'b0, 1'b1, 2'b00, 1'b0);
    thrash_win = 1'b0;
    chk("thrash_no_hs", thrash_bad, 0);

    repeat (40) cyc(4'b0, 1'b1, 2'b00, 1'b0);
    repeat (10) cyc(4'b0, 1'b1, 2'b01, 1'b0);
    chk("div_frozen_in_hs", cpuclk_div_sel, 0);
    repeat (10) cyc(4'b1000, 1'b1, 2'b01, 1'b0);
    chk("div_applied_in_ls", cpuclk_div_sel, 1);

    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(1, 25);
      rq = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      repeat (n) cyc(rq, ($urandom_range(0, 7) != 0),
                     2'($urandom_range(0, 2)), 1'b0);
    end
    repeat (40) cyc(4'b0, 1'b1, 2'b10, 1'b0);

    repeat (10) cyc(4'b0010, 1'b1, 2'b00, 1'b0);
    mux_hs_ok = 1'b0;
    repeat (300) cyc(4'b0, 1'b1, 2'b00, 1'b0);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_in_ls", {hsclk_sel, busy, mode_hs}, 0);
    mux_hs_ok = 1'b1;
    repeat (40) cyc(4'b0, 1'b1, 2'b00, 1'b0);
    chk("err_pins_ls", hsclk_sel, 0);

    repeat (2) cyc(4'b0, 1'b1, 2'b00, 1'b1);
    chk("err_cleared_by_rst", timeout_err, 0);
    rise_armed = 1'b1;
    repeat (18) cyc(4'b0, 1'b1, 2'b00, 1'b0);
    chk("mid_switch_busy", {hsclk_sel, busy}, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        {hsclk_sel, cpuclk_div_sel, slow_gnt, mode_hs, busy, timeout_err}, 0);
    void'(expq.pop_back());
    model_reset();
    expq.push_back(mo);
    repeat (3) cyc(4'b0, 1'b1, 2'b00, 1'b1);
    rise_armed = 1'b1;
    repeat (40) cyc(4'b0, 1'b1, 2'b00, 1'b0);
    chk("restart_hs", mode_hs, 1);

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
